// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Round-robin arbiter that shares one UART transmit byte path among NUM_REQ
// byte-stream requesters. Each grant optionally starts with a channel-ID header
// byte (8'hA0 | id). A grant is held until the message ends (req_last), the
// burst limit is reached, or the granted requester stays silent for
// GAP_TIMEOUT cycles. Data is passed through combinationally; nothing is
// stored inside the arbiter.
//
// Handshake: every byte stream uses valid/ready. A byte moves on a cycle where
// valid and ready are both high; valid may be raised regardless of ready, and
// a producer holding valid keeps its data stable until the transfer happens.
//
// Ports
//   clk, reset     clock, synchronous active-high reset
//   req_valid[i]   requester i presents a byte
//   req_data       requester i's byte at [8i+7:8i]
//   req_last[i]    the presented byte ends its message
//   req_ready[i]   requester i's byte is accepted this cycle
//   out_valid      byte toward the serializer is valid
//   out_data       byte toward the serializer (0 when out_valid is low)
//   out_ready      serializer accepts the byte this cycle
//   grant_id       index of the current or most recent grant
//   busy           registered, high while in HEADER or DATA
//   dbg_state      FSM state: 0 = IDLE, 1 = HEADER, 2 = DATA
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter bit HEADER_EN   = 1'b1,
    parameter int MAX_BURST   = 16,
    parameter int GAP_TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 out_valid,
    output logic [7:0]           out_data,
    input  logic                 out_ready,
    output logic [3:0]           grant_id,
    output logic                 busy,
    output logic [1:0]           dbg_state
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_DATA   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [7:0]       burst_cnt_q, burst_cnt_d;
    logic [11:0]      gap_cnt_q, gap_cnt_d;
    logic             busy_q, busy_d;

    logic [7:0]       req_byte [NUM_REQ];
    logic             sel_found;
    logic [IDX_W-1:0] sel_idx;
    logic [IDX_W:0]   cand;
    logic             g_valid;
    logic             g_last;
    logic [7:0]       g_byte;
    logic [7:0]       burst_inc;
    logic [11:0]      gap_inc;
    logic             release_grant;

    // Unpack the flat data bus so the granted byte is a simple array lookup.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_byte[i] = req_data[i*8 +: 8];
        end
    end

    assign g_valid = req_valid[grant_q];
    assign g_last  = req_last[grant_q];
    assign g_byte  = req_byte[grant_q];

    // First valid requester scanning upward from rr_ptr, wrapping to 0.
    // cand carries one extra bit so the wrap test cannot overflow.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NUM_REQ)) begin
                cand = cand - (IDX_W+1)'(NUM_REQ);
            end
            if (!sel_found && req_valid[cand[IDX_W-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        rr_ptr_d      = rr_ptr_q;
        burst_cnt_d   = burst_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        out_valid     = 1'b0;
        out_data      = 8'h00;
        req_ready     = '0;
        release_grant = 1'b0;
        burst_inc     = burst_cnt_q + 8'd1;
        gap_inc       = gap_cnt_q + 12'd1;

        case (state_q)
            ST_IDLE: begin
                if (sel_found) begin
                    grant_d     = sel_idx;
                    burst_cnt_d = '0;
                    gap_cnt_d   = '0;
                    state_d     = HEADER_EN ? ST_HEADER : ST_DATA;
                end
            end

            ST_HEADER: begin
                out_valid = 1'b1;
                out_data  = 8'hA0 | 8'(grant_q);
                if (out_ready) begin
                    state_d = ST_DATA;
                end
            end

            ST_DATA: begin
                out_valid          = g_valid;
                out_data           = g_valid ? g_byte : 8'h00;
                req_ready[grant_q] = out_ready;
                if (g_valid) begin
                    gap_cnt_d = '0;
                    if (out_ready) begin
                        burst_cnt_d = burst_inc;
                        if (g_last || (burst_inc == 8'(MAX_BURST))) begin
                            release_grant = 1'b1;
                        end
                    end
                end else begin
                    // A silent cycle: no byte moves, the timeout may fire.
                    gap_cnt_d = gap_inc;
                    if (gap_inc == 12'(GAP_TIMEOUT)) begin
                        release_grant = 1'b1;
                    end
                end
                if (release_grant) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + IDX_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Nothing is offered or accepted during reset, so a byte presented in
        // that cycle stays with its requester.
        if (reset) begin
            out_valid = 1'b0;
            out_data  = 8'h00;
            req_ready = '0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
            gap_cnt_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            busy_q      <= busy_d;
        end
    end

    assign grant_id  = 4'(grant_q);
    assign busy      = busy_q;
    assign dbg_state = state_q;

endmodule
